ifu_fetch: RTL and testbench

- Instruction fetch unit for the single-cycle-timing RISC-V core.
- Holds the architectural PC and fetches one instruction word at a time over a req/ack instruction-memory handshake.
- Presents the word to the decode/control logic. Op, Funct3 and Funct7 are sliced from inst.
- Consumes the NPCOp encoding produced by the control decoder to select the next PC when execute commits.

---
 rtl/ifu_fetch.sv | 113 +++++++++++
 tb/tb_ifu_fetch.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the PC, fetches one word per instruction over req/ack,
// and selects the next PC on commit. Optional counters enabled by IFU_PERF_CNT_EN.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  npc_op,
  input  logic [31:0] imm,
  input  logic [31:0] alu_out,
  input  logic        commit,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        fetch_fault
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_retired,
  output logic [31:0] perf_fetch_stall
`endif
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

  state_t      state_reg, state_next;
  logic        req_reg;
  logic [31:0] pc_reg;
  logic [31:0] inst_reg;
  logic [31:0] target;
  logic        fetch_done;
  logic        commit_ok;
  logic        misaligned;

  // Ack only counts once the request is actually on the bus.
  assign fetch_done = (state_reg == S_FETCH) && req_reg && imem_ack;
  assign commit_ok  = (state_reg == S_EXEC) && commit;
  assign misaligned = (target[1:0] != 2'b00);

  always_comb begin
    target = pc_reg + 32'd4;
    if (npc_op[2])
      target = {alu_out[31:1], 1'b0};
    else if (npc_op[1] || npc_op[0])
      target = pc_reg + imm;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state_reg <= S_FETCH;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH: if (fetch_done) state_next = S_EXEC;
      S_EXEC:  if (commit_ok)  state_next = misaligned ? S_HALT : S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_HALT;
    endcase
  end

  // The request register follows the next state so a fresh fetch starts the cycle after commit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_reg  <= 1'b0;
      pc_reg   <= RESET_PC;
      inst_reg <= NOP_INST;
    end else begin
      req_reg <= (state_next == S_FETCH);
      if (fetch_done)
        inst_reg <= imem_rdata;
      if (commit_ok && !misaligned)
        pc_reg <= target;
    end
  end

  always_comb begin
    imem_req    = req_reg;
    imem_addr   = pc_reg;
    pc          = pc_reg;
    inst_valid  = (state_reg == S_EXEC);
    inst        = (state_reg == S_EXEC) ? inst_reg : NOP_INST;
    fetch_fault = (state_reg == S_HALT);
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] retired_reg;
  logic [31:0] stall_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retired_reg <= 32'd0;
      stall_reg   <= 32'd0;
    end else begin
      if (commit_ok)
        retired_reg <= retired_reg + 32'd1;
      if ((state_reg == S_FETCH) && req_reg && !imem_ack)
        stall_reg <= stall_reg + 32'd1;
    end
  end

  assign perf_retired     = retired_reg;
  assign perf_fetch_stall = stall_reg;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: vector table, hand sequences, and randomized
// instructions checked against a transaction-level next-PC model.
module tb_ifu_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  npc_op;
  logic [31:0] imm;
  logic [31:0] alu_out;
  logic        commit;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic        fetch_fault;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_retired;
  logic [31:0] perf_fetch_stall;
`endif

  ifu_fetch dut (
    .clk(clk), .rstn(rstn), .npc_op(npc_op), .imm(imm), .alu_out(alu_out),
    .commit(commit), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc), .inst(inst),
    .inst_valid(inst_valid), .fetch_fault(fetch_fault)
`ifdef IFU_PERF_CNT_EN
    , .perf_retired(perf_retired), .perf_fetch_stall(perf_fetch_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_pc;
  logic [31:0] m_retired;
  logic [31:0] m_stall;

  typedef struct {
    int          delay;
    logic [2:0]  op;
    logic [31:0] imm_v;
    logic [31:0] alu_v;
    logic [31:0] exp_pc;
    bit          exp_fault;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Next PC from the ISA rules: jalr beats jal beats branch, otherwise sequential.
  function automatic logic [31:0] ref_target(input logic [31:0] cur, input logic [2:0] op,
                                             input logic [31:0] iv, input logic [31:0] av);
    if (op[2] == 1'b1) return av & 32'hFFFF_FFFE;
    if (op[1] == 1'b1) return cur + iv;
    if (op[0] == 1'b1) return cur + iv;
    return cur + 32'd4;
  endfunction

  task automatic check_perf();
`ifdef IFU_PERF_CNT_EN
    check("perf_retired", perf_retired, m_retired);
    check("perf_fetch_stall", perf_fetch_stall, m_stall);
`endif
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"}, pc, 32'h0);
    check({tag, "_inst"}, inst, NOP);
    check({tag, "_valid"}, {31'b0, inst_valid}, 32'h0);
    check({tag, "_req"}, {31'b0, imem_req}, 32'h0);
    check({tag, "_fault"}, {31'b0, fetch_fault}, 32'h0);
  endtask

  // Asserts reset mid-cycle so the asynchronous clear is observed before any edge.
  task automatic do_reset();
    rstn = 1'b0; imem_ack = 1'b0; commit = 1'b0;
    #1;
    m_pc = 32'h0; m_retired = 32'h0; m_stall = 32'h0;
    check_reset_values("rst_async");
    check_perf();
    step();
    step();
    rstn = 1'b1;
    check("rst_release_req", {31'b0, imem_req}, 32'h0);
    step();
    $display("txn reset pc=0x%08h req=%0b", pc, imem_req);
  endtask

  task automatic run_insn(input int delay, input logic [2:0] op, input logic [31:0] iv,
                          input logic [31:0] av, input logic [31:0] exp_pc, input bit exp_fault,
                          input bit spur);
    logic [31:0] word;
    word = $urandom;
    for (int k = 0; k < delay; k++) begin
      check("wait_req", {31'b0, imem_req}, 32'h1);
      check("wait_addr", imem_addr, m_pc);
      if (spur) begin
        commit = 1'b1; npc_op = 3'b100; alu_out = 32'h3;
      end
      step();
      commit = 1'b0;
    end
    check("fetch_req", {31'b0, imem_req}, 32'h1);
    check("fetch_addr", imem_addr, m_pc);
    check("fetch_valid", {31'b0, inst_valid}, 32'h0);
    imem_ack = 1'b1; imem_rdata = word;
    step();
    imem_ack = 1'b0;
    check("exec_valid", {31'b0, inst_valid}, 32'h1);
    check("exec_inst", inst, word);
    check("exec_pc", pc, m_pc);
    check("exec_req", {31'b0, imem_req}, 32'h0);
    if (spur) begin
      imem_ack = 1'b1; imem_rdata = ~word;
      step();
      imem_ack = 1'b0;
      check("spur_ack_inst", inst, word);
      check("spur_ack_valid", {31'b0, inst_valid}, 32'h1);
    end
    npc_op = op; imm = iv; alu_out = av; commit = 1'b1;
    step();
    commit = 1'b0;
    m_retired = m_retired + 32'd1;
    m_stall = m_stall + delay;
    check("commit_fault", {31'b0, fetch_fault}, {31'b0, exp_fault});
    check("commit_valid", {31'b0, inst_valid}, 32'h0);
    check("commit_inst", inst, NOP);
    if (exp_fault) begin
      check("fault_req", {31'b0, imem_req}, 32'h0);
      check("fault_pc", pc, m_pc);
    end else begin
      check("next_req", {31'b0, imem_req}, 32'h1);
      check("next_addr", imem_addr, exp_pc);
      m_pc = exp_pc;
    end
    check_perf();
    $display("txn op=%03b imm=0x%08h alu=0x%08h delay=%0d -> pc=0x%08h fault=%0b",
             op, iv, av, delay, pc, fetch_fault);
  endtask

  task automatic check_halt();
    logic [31:0] held;
    held = pc;
    for (int k = 0; k < 3; k++) begin
      imem_ack = 1'b1; commit = 1'b1; npc_op = 3'b000;
      step();
      check("halt_req", {31'b0, imem_req}, 32'h0);
      check("halt_fault", {31'b0, fetch_fault}, 32'h1);
      check("halt_valid", {31'b0, inst_valid}, 32'h0);
      check("halt_pc", pc, held);
    end
    imem_ack = 1'b0; commit = 1'b0;
    check_perf();
    $display("txn halt pc=0x%08h", pc);
  endtask

  initial begin
    vecs[0]  = '{0, 3'b000, 32'h0,         32'h0,         32'h0000_0004, 1'b0};
    vecs[1]  = '{3, 3'b010, 32'h0000_00FC, 32'h0,         32'h0000_0100, 1'b0};
    vecs[2]  = '{0, 3'b001, 32'hFFFF_FFF0, 32'h0,         32'h0000_00F0, 1'b0};
    vecs[3]  = '{1, 3'b100, 32'h0,         32'h0000_0111, 32'h0000_0110, 1'b0};
    vecs[4]  = '{0, 3'b001, 32'hFFFF_FFF0, 32'h0,         32'h0000_0100, 1'b0};
    vecs[5]  = '{0, 3'b010, 32'h0000_0020, 32'h0,         32'h0000_0120, 1'b0};
    vecs[6]  = '{2, 3'b100, 32'h0,         32'h0000_0010, 32'h0000_0010, 1'b0};
    vecs[7]  = '{0, 3'b110, 32'h0000_0008, 32'h0000_0400, 32'h0000_0400, 1'b0};
    vecs[8]  = '{0, 3'b011, 32'h0000_0008, 32'h0000_0800, 32'h0000_0408, 1'b0};
    vecs[9]  = '{1, 3'b101, 32'h0000_0004, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 1'b0};
    vecs[10] = '{0, 3'b000, 32'h0,         32'h0,         32'h0000_0000, 1'b0};
    vecs[11] = '{0, 3'b010, 32'h0000_0100, 32'h0,         32'h0000_0100, 1'b0};
    vecs[12] = '{0, 3'b100, 32'h0,         32'h0000_0203, 32'h0000_0100, 1'b1};

    rstn = 1'b0; npc_op = 3'b000; imm = 32'h0; alu_out = 32'h0;
    commit = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    m_pc = 32'h0; m_retired = 32'h0; m_stall = 32'h0;
    step();
    do_reset();

    foreach (vecs[i])
      run_insn(vecs[i].delay, vecs[i].op, vecs[i].imm_v, vecs[i].alu_v,
               vecs[i].exp_pc, vecs[i].exp_fault, (i % 3) == 1);
    check_halt();

    // Memory ack held high from reset release: the ack before req rises is ignored.
    rstn = 1'b0; #1;
    m_pc = 32'h0; m_retired = 32'h0; m_stall = 32'h0;
    check_reset_values("rst_from_halt");
    step();
    rstn = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0040_0093;
    step();
    check("tied_req_c0", {31'b0, imem_req}, 32'h1);
    check("tied_valid_c0", {31'b0, inst_valid}, 32'h0);
    step();
    imem_ack = 1'b0;
    check("tied_valid_c1", {31'b0, inst_valid}, 32'h1);
    check("tied_pc_c1", pc, 32'h0);
    check("tied_inst_c1", inst, 32'h0040_0093);
    npc_op = 3'b000; commit = 1'b1;
    step();
    commit = 1'b0;
    check("tied_next_addr", imem_addr, 32'h4);
    check("tied_next_req", {31'b0, imem_req}, 32'h1);
    m_pc = 32'h4; m_retired = 32'h1;
    $display("txn tied_ack -> addr=0x%08h", imem_addr);

    // Reset pulse while a fetch at 0x40 is waiting for ack.
    run_insn(0, 3'b010, 32'h0000_003C, 32'h0, 32'h0000_0040, 1'b0, 1'b0);
    step();
    step();
    check("abort_addr", imem_addr, 32'h40);
    do_reset();

    for (int n = 0; n < 60; n++) begin
      logic [2:0]  op;
      logic [31:0] iv, av, tgt;
      bit          flt;
      op = 3'($urandom);
      iv = $urandom_range(0, 15) == 0 ? $urandom : ($urandom & 32'hFFFF_FFFC);
      if ($urandom_range(0, 1) == 1) iv = {{20{iv[11]}}, iv[11:0]};
      av = $urandom_range(0, 9) == 0 ? $urandom : ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
      tgt = ref_target(m_pc, op, iv, av);
      flt = (tgt % 4) != 0;
      run_insn($urandom_range(0, 3), op, iv, av, tgt, flt, $urandom_range(0, 1) == 1);
      if (flt) begin
        check_halt();
        do_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
